// File: rtl/seq_detect_n_if.sv
// seq_detect_n_if: stream and status bundle for the seq_detect_n pattern detector.
//   master modport (stream source / monitor):
//     drives   load, pattern[WIDTH], overlap, valid, x, cnt_clr
//     receives y, hit, armed, count[CNT_W]
//   slave modport (the detector) sees the same signals with the directions reversed.
// Clock and reset are plain ports on the detector and are not part of this bundle.
interface seq_detect_n_if #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned CNT_W = 8
);
  logic             load;
  logic [WIDTH-1:0] pattern;
  logic             overlap;
  logic             valid;
  logic             x;
  logic             cnt_clr;
  logic             y;
  logic             hit;
  logic             armed;
  logic [CNT_W-1:0] count;

  modport master (
    output load, pattern, overlap, valid, x, cnt_clr,
    input  y, hit, armed, count
  );

  modport slave (
    input  load, pattern, overlap, valid, x, cnt_clr,
    output y, hit, armed, count
  );
endinterface

// File: rtl/seq_detect_n.sv
// seq_detect_n: run-time loadable serial pattern detector for a single-bit stream.
// It flags each completed occurrence of the loaded pattern combinationally (y) and one
// cycle later (hit). Matches may be overlapping or non-overlapping, and a saturating
// counter records how many matches have occurred.
//   clk    : rising-edge clock
//   reset  : synchronous, active-high reset
//   bus    : seq_detect_n_if.slave
//            load, pattern (MSB is the first bit received), overlap, valid, x, cnt_clr
//            -> y (Mealy match), hit (y registered), armed (FILL or DETECT), count
// Build option: define SEQDET_COUNT_EN to build the match counter. When it is undefined,
// count is tied to 0 and cnt_clr is ignored.
module seq_detect_n #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned CNT_W = 8
) (
  input logic          clk,
  input logic          reset,
  seq_detect_n_if.slave bus
);

  localparam int unsigned HistW = WIDTH - 1;
  localparam int unsigned FillW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StDetect
  } state_e;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [WIDTH-1:0]  r_pat;
  logic [WIDTH-1:0]  w_pat_nxt;
  logic [HistW-1:0]  r_hist;
  logic [HistW-1:0]  w_hist_nxt;
  logic [FillW-1:0]  r_fill;
  logic [FillW-1:0]  w_fill_nxt;
  logic              r_hit;
  logic              r_armed;

  logic              w_accept;
  logic              w_match;
  logic              w_y;
  logic [HistW-1:0]  w_hist_shift;

  // The history plus the current bit forms the candidate; the oldest bit is the MSB.
  assign w_match      = ({r_hist, bus.x} == r_pat);
  assign w_accept     = bus.valid & ~bus.load & (r_state != StIdle);
  assign w_y          = (r_state == StDetect) & bus.valid & ~bus.load & w_match;
  // Dropping the MSB of {hist, x} keeps the newest WIDTH-1 bits.
  assign w_hist_shift = HistW'({r_hist, bus.x});

  always_comb begin
    w_state_nxt = r_state;
    w_pat_nxt   = r_pat;
    w_hist_nxt  = r_hist;
    w_fill_nxt  = r_fill;
    if (bus.load) begin
      w_state_nxt = StFill;
      w_pat_nxt   = bus.pattern;
      w_hist_nxt  = '0;
      w_fill_nxt  = '0;
    end else if (w_accept) begin
      case (r_state)
        StFill: begin
          w_hist_nxt = w_hist_shift;
          w_fill_nxt = r_fill + FillW'(1);
          if (r_fill == FillW'(WIDTH - 2)) begin
            w_state_nxt = StDetect;
          end
        end
        StDetect: begin
          if (w_match && !bus.overlap) begin
            // Non-overlapping: the matched bits cannot start the next occurrence.
            w_state_nxt = StFill;
            w_hist_nxt  = '0;
            w_fill_nxt  = '0;
          end else begin
            w_hist_nxt = w_hist_shift;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_pat   <= '0;
      r_hist  <= '0;
      r_fill  <= '0;
      r_hit   <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pat   <= w_pat_nxt;
      r_hist  <= w_hist_nxt;
      r_fill  <= w_fill_nxt;
      r_hit   <= w_y;
      r_armed <= (w_state_nxt != StIdle);
    end
  end

`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0] r_count;

  // Clear wins over a same-cycle match; the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (bus.cnt_clr) begin
      r_count <= '0;
    end else if (w_y && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign bus.count = r_count;
`else
  logic w_unused_cnt_clr;
  assign w_unused_cnt_clr = bus.cnt_clr;
  assign bus.count        = '0;
`endif

  assign bus.y     = w_y;
  assign bus.hit   = r_hit;
  assign bus.armed = r_armed;

endmodule

// File: tb/tb_seq_detect_n.sv
module tb_seq_detect_n;
  localparam int unsigned W  = 3;
  localparam int unsigned CW = 2;
  localparam int          CntMax = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;

  seq_detect_n_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  seq_detect_n #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a record of accepted bits since the last restart.
  bit         m_loaded = 1'b0;
  bit         m_bits[$];
  logic [W-1:0] m_pat = '0;
  int         m_count = 0;
  bit         m_hit = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_cnt(input int c);
`ifdef SEQDET_COUNT_EN
    return c;
`else
    return 0;
`endif
  endfunction

  // Match if the last W-1 accepted bits followed by x spell the loaded pattern.
  function automatic bit model_y(input bit v, input bit xx, input bit ld);
    int val;
    int n;
    if (!m_loaded || !v || ld) return 1'b0;
    n = m_bits.size();
    if (n < W - 1) return 1'b0;
    val = 0;
    for (int i = n - (W - 1); i < n; i++) val = val * 2 + int'(m_bits[i]);
    val = val * 2 + int'(xx);
    return (val == int'(m_pat));
  endfunction

  task automatic step(input bit v, input bit xx, input bit ld, input bit clr, input bit rst,
                      input bit ov, input logic [W-1:0] pat);
    bit ey;
    @(negedge clk);
    reset       = rst;
    bus.valid   = v;
    bus.x       = xx;
    bus.load    = ld;
    bus.cnt_clr = clr;
    bus.overlap = ov;
    bus.pattern = pat;
    #1;
    ey = rst ? 1'b0 : model_y(v, xx, ld);
    if (!rst) chk("y", 32'(bus.y), 32'(ey));
    @(posedge clk);
    #1;
    if (rst) begin
      m_loaded = 1'b0;
      m_bits.delete();
      m_pat   = '0;
      m_count = 0;
      m_hit   = 1'b0;
    end else begin
      m_hit = ey;
      if (clr) m_count = 0;
      else if (ey && m_count < CntMax) m_count++;
      if (ld) begin
        m_loaded = 1'b1;
        m_pat    = pat;
        m_bits.delete();
      end else if (v && m_loaded) begin
        if (ey && !ov) begin
          m_bits.delete();
        end else begin
          m_bits.push_back(xx);
          if (m_bits.size() > W - 1) void'(m_bits.pop_front());
        end
      end
    end
    chk("hit", 32'(bus.hit), 32'(m_hit));
    chk("armed", 32'(bus.armed), 32'(m_loaded));
    chk("count", 32'(bus.count), 32'(exp_cnt(m_count)));
  endtask

  // Shorthand for a plain stream bit.
  task automatic bitin(input bit xx, input bit ov);
    step(1'b1, xx, 1'b0, 1'b0, 1'b0, ov, 3'b000);
  endtask

  initial begin
    bus.valid   = 1'b0;
    bus.x       = 1'b0;
    bus.load    = 1'b0;
    bus.cnt_clr = 1'b0;
    bus.overlap = 1'b0;
    bus.pattern = '0;

    // Reset and idle: stream bits without a load are ignored.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000);
    chk("reset_armed", 32'(bus.armed), 32'd0);
    chk("reset_count", 32'(bus.count), 32'd0);
    bitin(1'b1, 1'b1);
    bitin(1'b0, 1'b1);
    bitin(1'b1, 1'b1);
    chk("idle_hit", 32'(bus.hit), 32'd0);

    // Overlap mode, 101 against 1,0,1,0,1: matches on bits 3 and 5.
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'b101);
    chk("load_armed", 32'(bus.armed), 32'd1);
    bitin(1'b1, 1'b1);
    bitin(1'b0, 1'b1);
    bitin(1'b1, 1'b1);
    chk("ov_hit3", 32'(bus.hit), 32'd1);
    bitin(1'b0, 1'b1);
    bitin(1'b1, 1'b1);
    chk("ov_hit5", 32'(bus.hit), 32'd1);
    chk("ov_count", 32'(bus.count), 32'(exp_cnt(2)));

    // Non-overlap mode: only bit 3 matches.
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b101);
    bitin(1'b1, 1'b0);
    bitin(1'b0, 1'b0);
    bitin(1'b1, 1'b0);
    bitin(1'b0, 1'b0);
    bitin(1'b1, 1'b0);
    chk("nov_hit5", 32'(bus.hit), 32'd0);
    chk("nov_count", 32'(bus.count), 32'(exp_cnt(1)));

    // Gaps, then a mid-stream reload whose own bit is discarded.
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'b101);
    bitin(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000);
    bitin(1'b0, 1'b1);
    bitin(1'b1, 1'b1);
    chk("gap_hit", 32'(bus.hit), 32'd1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b110);
    bitin(1'b1, 1'b1);
    bitin(1'b1, 1'b1);
    bitin(1'b0, 1'b1);
    chk("reload_hit", 32'(bus.hit), 32'd1);
    chk("reload_count", 32'(bus.count), 32'(exp_cnt(2)));

    // Saturation at 3, then a clear in the same cycle as a match.
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'b111);
    for (int i = 0; i < 8; i++) bitin(1'b1, 1'b1);
    chk("sat_count", 32'(bus.count), 32'(exp_cnt(3)));
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000);
    chk("clr_hit", 32'(bus.hit), 32'd1);
    chk("clr_count", 32'(bus.count), 32'd0);

    // Mid-stream reset aborts a partial match.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b101);
    bitin(1'b1, 1'b1);
    bitin(1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000);
    chk("rst_armed", 32'(bus.armed), 32'd0);
    bitin(1'b1, 1'b1);
    chk("rst_hit", 32'(bus.hit), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(3) != 0), 1'($urandom()), ($urandom_range(15) == 0),
           ($urandom_range(15) == 0), ($urandom_range(63) == 0), 1'($urandom()),
           W'($urandom()));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_detect_n.md
# seq_detect_n

Parametrised serial pattern detector for single-bit streams. It is the next generation of the fixed "101" Mealy detector FSM. It generalises pattern length, makes the pattern loadable at run time, qualifies each input bit with a valid strobe, and adds a selectable overlapping/non-overlapping match mode and a saturating match counter. It sits on a serial input path and flags each completed occurrence of the pattern, both combinationally and registered.

## Interface
- `WIDTH`, default 3: pattern length in bits; legal range 2..16.
- `CNT_W`, default 8: match counter width; legal range 1..32.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `load`, input, 1: capture `pattern` and restart detection.
- `pattern`, input, WIDTH: target sequence. The MSB is the first bit received.
- `overlap`, input, 1: 1 = overlapping matches, 0 = non-overlapping. Sampled every cycle.
- `valid`, input, 1: `x` carries a stream bit this cycle.
- `x`, input, 1: serial data bit.
- `cnt_clr`, input, 1: clear the match counter.
- `y`, output, 1: Mealy match flag; combinational from the current state and `valid`/`x`.
- `hit`, output, 1: `y` registered; one-cycle pulse.
- `armed`, output, 1: high in FILL or DETECT.
- `count`, output, CNT_W: number of matches, saturating.

## Operation
- Internal registers:
  - `pat_r` (WIDTH): loaded pattern.
  - `hist` (WIDTH-1): last accepted bits, newest in the LSB.
  - `fill` (0..WIDTH-1): number of bits accepted since the last restart.
- A bit is accepted when `valid`=1, `load`=0 and the state is not IDLE.
- States:
  - IDLE: after reset, no pattern loaded. Valid bits are ignored; `y`=0.
  - FILL: `fill` < WIDTH-1.
  - DETECT: `fill` = WIDTH-1.
- Transitions:
  - Any state, `load`=1 → FILL, with `pat_r`=`pattern`, `hist`=0, `fill`=0.
  - FILL, accepted bit: shift into `hist` and increment `fill`. When `fill` reaches WIDTH-1, go to DETECT.
  - DETECT, accepted bit: match is `{hist, x} == pat_r`. With no match, shift and stay in DETECT.
  - DETECT, match with `overlap`=1: shift and stay in DETECT.
  - DETECT, match with `overlap`=0: go to FILL with `hist`=0, `fill`=0.
- `y` = (state==DETECT) & `valid` & !`load` & match. It is never 1 in IDLE or FILL.
- Counter behaviour:
  - Increments by 1 on each cycle with `y`=1.
  - Saturates at 2^CNT_W−1 and never wraps.
  - `cnt_clr` has priority over the increment in the same cycle (result 0).
  - `load` does not clear `count`.
- `overlap` may change at any time; it takes effect on the next match.

## Timing
- Reset values: state=IDLE, `pat_r`=0, `hist`=0, `fill`=0, `hit`=0, `armed`=0, `count`=0. `y`=0 while in IDLE.
- Reset asserted mid-stream aborts any partial match. The first match after reset requires a new `load` followed by WIDTH accepted bits.
- Latency: `y` in the same cycle as the final pattern bit. `hit` one cycle later. `count` updated on the clock edge that closes the matching cycle.
- A `load` cycle discards that cycle's `x`. The first accepted bit is the one on the following valid cycle.
- `valid`=0 cycles hold all state. Gaps are transparent to matching.
- Minimum match spacing:
  - Overlap mode: the pattern's period, which can be 1 cycle (for example, all-ones patterns).
  - Non-overlap mode: WIDTH accepted bits.
- `armed` is registered and reflects the state after each edge.

## Configuration
- `SEQDET_COUNT_EN` defined: the counter, `cnt_clr` logic and `count` output behave as above.
- `SEQDET_COUNT_EN` undefined: no counter register is built. `count` is tied to 0 and `cnt_clr` is ignored. `y`, `hit` and `armed` are unchanged.

## Test plan
- Reset and idle:
  - Stimulus: `reset`=1 for 2 cycles, then `valid`=1 with `x`=1,0,1 and no load.
  - Required: `y`=`hit`=`armed`=0 and `count`=0 throughout.
- Overlap mode:
  - Stimulus: WIDTH=3, load 3'b101, `overlap`=1, stream 1,0,1,0,1.
  - Required: `y`=1 on bits 3 and 5 only; `hit` one cycle after each; `count`=2.
- Non-overlap mode:
  - Stimulus: same stream with `overlap`=0.
  - Required: `y`=1 on bit 3 only; `count`=1.
- Gaps and reload:
  - Stimulus: stream 1, gap of 3 `valid`=0 cycles, then 0,1. Then load 3'b110 mid-stream, followed by 1,1,0.
  - Required: match on the gapped sequence. The load-cycle bit is discarded. Match on the final 0. `count`=2.
- Saturation and clear:
  - Stimulus: CNT_W=2, overlap on, pattern 3'b111, stream of eight 1s. Then `cnt_clr` asserted in the same cycle as a match.
  - Required: `count` reaches 3 and holds there. After the clear-and-match cycle, `count`=0.
- Mid-stream reset and counter compiled out:
  - Stimulus: assert `reset` after bits 1,0 of pattern 101.
  - Required: `armed`=0 and a following 1 gives no match.
  - With `SEQDET_COUNT_EN` undefined, `count` stays 0 across all of the above.
